// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl
//   640x480@60 raster scan controller. It runs the screen counters and decodes
//   the active-low syncs and the active-area flag. Inside a centred window it
//   issues render-coordinate fetches for a 2x scaled render image. The syncs
//   and flags are delayed so they line up with the pixels that come back from
//   the framebuffer.
//
// Optional feature macro: VGA_SCAN_BORDER_EN
//   defined   : active pixels outside the render window show BORDER_RGB
//   undefined : those pixels show 0 (BORDER_RGB has no effect)
//
// Ports
//   clk         in   pixel clock
//   rst         in   asynchronous, active-low reset
//   en          in   scan enable (dropping it finishes the current frame)
//   rend_req    out  fetch request; rendx/rendy are valid while it is high
//   rendx       out  render x coordinate
//   rendy       out  render y coordinate
//   rgb_in      in   framebuffer pixel, FETCH_LAT cycles after rend_req
//   rgb_out     out  pixel aligned with the syncs ({b,g,r})
//   hsync_out   out  active-low horizontal sync
//   vsync_out   out  active-low vertical sync
//   de_out      out  active-area flag
//   frame_start out  one-cycle pulse with the first pixel of a frame
//   busy        out  high while scanning (state RUN)
module vga_scan_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int RCoorBits  = 8,
  parameter int REND_W     = 256,
  parameter int REND_H     = 180,
  parameter int SCALE_LOG2 = 1,
  parameter int X_OFF      = 64,
  parameter int Y_OFF      = 60,
  parameter int FETCH_LAT  = 1,
  parameter int bpc        = 4,
  parameter logic [3*bpc-1:0] BORDER_RGB = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 rend_req,
  output logic [RCoorBits-1:0] rendx,
  output logic [RCoorBits-1:0] rendy,
  input  logic [3*bpc-1:0]     rgb_in,
  output logic [3*bpc-1:0]     rgb_out,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic                 de_out,
  output logic                 frame_start,
  output logic                 busy
);

  localparam int PIX_W   = 3 * bpc;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);

  localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);

  // Sync pulses cover [BEG, END); the window covers [OFF, OFF + scaled size).
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;
  localparam int WX_END = X_OFF + (REND_W << SCALE_LOG2);
  localparam int WY_END = Y_OFF + (REND_H << SCALE_LOG2);

`ifdef VGA_SCAN_BORDER_EN
  localparam logic BORDER_ON = 1'b1;
`else
  localparam logic BORDER_ON = 1'b0;
`endif
  localparam logic [PIX_W-1:0] FILL_RGB = BORDER_ON ? BORDER_RGB : '0;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic win;
    logic fs;
  } ctl_t;

  localparam ctl_t CTL_BLANK = '{hs: 1'b1, vs: 1'b1, de: 1'b0, win: 1'b0, fs: 1'b0};

  state_t            state;
  logic [HC_W-1:0]   hcount;
  logic [VC_W-1:0]   vcount;
  int                hc;
  int                vc;
  ctl_t              ctl_dec;
  logic [RCoorBits-1:0] rx_dec;
  logic [RCoorBits-1:0] ry_dec;
  // ctl_p[0] lines up with rend_*, ctl_p[FETCH_LAT] lines up with rgb_in.
  ctl_t              ctl_p [0:FETCH_LAT];

  function automatic logic [RCoorBits-1:0] rend_coord(input int pos, input int off);
    return RCoorBits'((pos - off) >> SCALE_LOG2);
  endfunction

  function automatic logic [PIX_W-1:0] pick_pixel(input ctl_t c, input logic [PIX_W-1:0] px);
    if (!c.de)
      return '0;
    else if (c.win)
      return px;
    else
      return FILL_RGB;
  endfunction

  // ---- Scan FSM and counters ----
  // A stop request only takes effect on the last pixel of the frame, so
  // raising en again before then simply keeps the scan running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      hcount <= '0;
      vcount <= '0;
    end else begin
      case (state)
        IDLE: begin
          hcount <= '0;
          vcount <= '0;
          if (en) state <= RUN;
        end
        RUN: begin
          if (hcount == H_LAST) begin
            hcount <= '0;
            if (vcount == V_LAST) begin
              vcount <= '0;
              if (!en) state <= IDLE;
            end else begin
              vcount <= vcount + VC_W'(1);
            end
          end else begin
            hcount <= hcount + HC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign hc   = int'(hcount);
  assign vc   = int'(vcount);

  // ---- Stage 0: position decode (blank while idle) ----
  always_comb begin
    ctl_dec = CTL_BLANK;
    rx_dec  = '0;
    ry_dec  = '0;
    if (busy) begin
      ctl_dec.hs  = !(hc >= HS_BEG && hc < HS_END);
      ctl_dec.vs  = !(vc >= VS_BEG && vc < VS_END);
      ctl_dec.de  = (hc < H_ACTIVE) && (vc < V_ACTIVE);
      ctl_dec.win = (hc >= X_OFF) && (hc < WX_END) && (vc >= Y_OFF) && (vc < WY_END);
      ctl_dec.fs  = (hc == 0) && (vc == 0);
      if (ctl_dec.win) begin
        rx_dec = rend_coord(hc, X_OFF);
        ry_dec = rend_coord(vc, Y_OFF);
      end
    end
  end

  // ---- Stage p0 (fetch request) and framebuffer-latency delay line ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rend_req <= 1'b0;
      rendx    <= '0;
      rendy    <= '0;
      for (int i = 0; i <= FETCH_LAT; i++) ctl_p[i] <= CTL_BLANK;
    end else begin
      rend_req <= ctl_dec.win;
      rendx    <= rx_dec;
      rendy    <= ry_dec;
      ctl_p[0] <= ctl_dec;
      for (int i = 1; i <= FETCH_LAT; i++) ctl_p[i] <= ctl_p[i-1];
    end
  end

  // ---- Output stage: merge returned pixel with aligned syncs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_out   <= 1'b1;
      vsync_out   <= 1'b1;
      de_out      <= 1'b0;
      frame_start <= 1'b0;
      rgb_out     <= '0;
    end else begin
      hsync_out   <= ctl_p[FETCH_LAT].hs;
      vsync_out   <= ctl_p[FETCH_LAT].vs;
      de_out      <= ctl_p[FETCH_LAT].de;
      frame_start <= ctl_p[FETCH_LAT].fs;
      rgb_out     <= pick_pixel(ctl_p[FETCH_LAT], rgb_in);
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl. dut_a uses the full 640x480 geometry and is used
// for the reset, first-fetch, sync and pixel-colour checks. dut_b uses a
// small geometry (24x17 total, 16x12 active, 12x8 window at (2,2)) so that
// whole frames, the window edge and the stop/restart behaviour fit in a
// short run. dut_b's framebuffer model returns {0, rendy[3:0], rendx[3:0]}
// one cycle after the request.
module tb_vga_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en_a, en_b;

`ifdef VGA_SCAN_BORDER_EN
  localparam logic [11:0] EXP_BORDER = 12'h00F;
`else
  localparam logic [11:0] EXP_BORDER = 12'h000;
`endif

  logic        rend_req_a, hsync_out_a, vsync_out_a, de_out_a, frame_start_a, busy_a;
  logic [7:0]  rendx_a, rendy_a;
  logic [11:0] rgb_in_a, rgb_out_a;

  logic        rend_req_b, hsync_out_b, vsync_out_b, de_out_b, frame_start_b, busy_b;
  logic [7:0]  rendx_b, rendy_b;
  logic [11:0] rgb_in_b, rgb_out_b;

  int errors = 0;
  int checks = 0;

  assign rgb_in_a = 12'hFFF;

  vga_scan_ctrl #(.BORDER_RGB(12'h00F)) dut_a (
    .clk(clk), .rst(rst), .en(en_a),
    .rend_req(rend_req_a), .rendx(rendx_a), .rendy(rendy_a),
    .rgb_in(rgb_in_a), .rgb_out(rgb_out_a),
    .hsync_out(hsync_out_a), .vsync_out(vsync_out_a), .de_out(de_out_a),
    .frame_start(frame_start_a), .busy(busy_a)
  );

  vga_scan_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .REND_W(6), .REND_H(4), .X_OFF(2), .Y_OFF(2),
    .BORDER_RGB(12'h00F)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en_b),
    .rend_req(rend_req_b), .rendx(rendx_b), .rendy(rendy_b),
    .rgb_in(rgb_in_b), .rgb_out(rgb_out_b),
    .hsync_out(hsync_out_b), .vsync_out(vsync_out_b), .de_out(de_out_b),
    .frame_start(frame_start_b), .busy(busy_b)
  );

  // Framebuffer model for dut_b: one-cycle read latency.
  always @(posedge clk) rgb_in_b <= {4'h0, rendy_b[3:0], rendx_b[3:0]};

  task automatic test_reset();
    rst = 1'b0; en_a = 1'b0; en_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({hsync_out_a, vsync_out_a, de_out_a, rend_req_a, frame_start_a, busy_a} !== 6'b110000)
      begin errors++; $display("FAIL reset_ctl: got %b expected 110000",
        {hsync_out_a, vsync_out_a, de_out_a, rend_req_a, frame_start_a, busy_a}); end
    checks++;
    if ({rgb_out_a, rendx_a, rendy_a} !== 28'h0)
      begin errors++; $display("FAIL reset_data: got %h expected 0", {rgb_out_a, rendx_a, rendy_a}); end
    rst = 1'b1; en_a = 1'b1;
    @(negedge clk);              // cycle with count (0,0)
    repeat (300) @(negedge clk); // count (300,0); output shows (297,0)
    checks++;
    if (de_out_a !== 1'b1 || busy_a !== 1'b1)
      begin errors++; $display("FAIL pre_reset_run: de=%b busy=%b expected 1 1", de_out_a, busy_a); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({hsync_out_a, vsync_out_a, de_out_a, rend_req_a, frame_start_a, busy_a} !== 6'b110000 ||
        {rgb_out_a, rendx_a, rendy_a} !== 28'h0)
      begin errors++; $display("FAIL midline_reset: got ctl=%b data=%h expected 110000 0",
        {hsync_out_a, vsync_out_a, de_out_a, rend_req_a, frame_start_a, busy_a},
        {rgb_out_a, rendx_a, rendy_a}); end
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (busy_a !== 1'b0)
      begin errors++; $display("FAIL busy_before_restart: got %b expected 0", busy_a); end
    @(negedge clk);              // cycle with restarted count (0,0)
  endtask

  task automatic test_first_fetch();
    int hs_low = 0, vs_low = 0, de_hi = 0;
    for (int j = 0; j <= 48067; j++) begin
      if (j >= 3 && j < 1603) begin
        hs_low += (hsync_out_a == 1'b0) ? 1 : 0;
        vs_low += (vsync_out_a == 1'b0) ? 1 : 0;
        de_hi  += (de_out_a == 1'b1) ? 1 : 0;
      end
      if (j == 0) begin
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL busy_run: got %b expected 1", busy_a); end
      end
      if (j == 2) begin
        checks++;
        if (frame_start_a !== 1'b0 || de_out_a !== 1'b0)
          begin errors++; $display("FAIL pre_first_pixel: fs=%b de=%b expected 0 0", frame_start_a, de_out_a); end
      end
      if (j == 3) begin
        checks++;
        if (frame_start_a !== 1'b1 || de_out_a !== 1'b1 || rgb_out_a !== EXP_BORDER)
          begin errors++; $display("FAIL first_pixel: fs=%b de=%b rgb=%h expected 1 1 %h",
            frame_start_a, de_out_a, rgb_out_a, EXP_BORDER); end
      end
      if (j == 4) begin
        checks++;
        if (frame_start_a !== 1'b0) begin errors++; $display("FAIL fs_width: got %b expected 0", frame_start_a); end
      end
      if (j == 658) begin
        checks++;
        if (hsync_out_a !== 1'b1) begin errors++; $display("FAIL hs_655: got %b expected 1", hsync_out_a); end
      end
      if (j == 659) begin
        checks++;
        if (hsync_out_a !== 1'b0) begin errors++; $display("FAIL hs_656: got %b expected 0", hsync_out_a); end
      end
      if (j == 1603) begin
        checks++;
        if (hs_low != 192 || vs_low != 0 || de_hi != 1280)
          begin errors++; $display("FAIL two_line_counts: hs_low=%0d vs_low=%0d de=%0d expected 192 0 1280",
            hs_low, vs_low, de_hi); end
      end
      if (j == 8013) begin
        checks++;
        if (rgb_out_a !== EXP_BORDER || de_out_a !== 1'b1)
          begin errors++; $display("FAIL border_10_10: rgb=%h de=%b expected %h 1", rgb_out_a, de_out_a, EXP_BORDER); end
      end
      if (j == 48064) begin
        checks++;
        if (rend_req_a !== 1'b0) begin errors++; $display("FAIL req_before_window: got %b expected 0", rend_req_a); end
      end
      if (j == 48065) begin
        checks++;
        if (rend_req_a !== 1'b1 || rendx_a !== 8'd0 || rendy_a !== 8'd0)
          begin errors++; $display("FAIL first_req: req=%b x=%0d y=%0d expected 1 0 0", rend_req_a, rendx_a, rendy_a); end
      end
      if (j == 48066) begin
        checks++;
        if (rend_req_a !== 1'b1 || rendx_a !== 8'd0 || rgb_out_a !== EXP_BORDER)
          begin errors++; $display("FAIL req_h65: req=%b x=%0d rgb=%h expected 1 0 %h",
            rend_req_a, rendx_a, rgb_out_a, EXP_BORDER); end
      end
      if (j == 48067) begin
        checks++;
        if (rendx_a !== 8'd1 || rgb_out_a !== 12'hFFF)
          begin errors++; $display("FAIL req_h66_pix_64_60: x=%0d rgb=%h expected 1 fff", rendx_a, rgb_out_a); end
      end
      @(negedge clk);
    end
    en_a = 1'b0;
  endtask

  task automatic test_window_and_stop();
    int hs_low = 0, vs_low = 0, de_hi = 0;
    en_b = 1'b1;
    @(negedge clk);              // dut_b count (0,0)
    for (int j = 0; j <= 420; j++) begin
      if (j >= 3 && j < 411) begin
        hs_low += (hsync_out_b == 1'b0) ? 1 : 0;
        vs_low += (vsync_out_b == 1'b0) ? 1 : 0;
        de_hi  += (de_out_b == 1'b1) ? 1 : 0;
      end
      if (j == 50) begin
        checks++;
        if (rend_req_b !== 1'b0) begin errors++; $display("FAIL b_req_before: got %b expected 0", rend_req_b); end
      end
      if (j == 51) begin
        checks++;
        if (rend_req_b !== 1'b1 || rendx_b !== 8'd0 || rendy_b !== 8'd0)
          begin errors++; $display("FAIL b_first_req: req=%b x=%0d y=%0d expected 1 0 0", rend_req_b, rendx_b, rendy_b); end
      end
      if (j == 230) begin
        checks++;
        if (rend_req_b !== 1'b1 || rendx_b !== 8'd5 || rendy_b !== 8'd3)
          begin errors++; $display("FAIL b_edge_in: req=%b x=%0d y=%0d expected 1 5 3", rend_req_b, rendx_b, rendy_b); end
      end
      if (j == 231) begin
        checks++;
        if (rend_req_b !== 1'b0 || rendx_b !== 8'd0 || rendy_b !== 8'd0)
          begin errors++; $display("FAIL b_edge_out: req=%b x=%0d y=%0d expected 0 0 0", rend_req_b, rendx_b, rendy_b); end
      end
      if (j == 232) begin
        checks++;
        if (rgb_out_b !== 12'h035) begin errors++; $display("FAIL b_edge_pixel: got %h expected 035", rgb_out_b); end
      end
      if (j == 233) begin
        checks++;
        if (rgb_out_b !== EXP_BORDER || de_out_b !== 1'b1)
          begin errors++; $display("FAIL b_edge_border: rgb=%h de=%b expected %h 1", rgb_out_b, de_out_b, EXP_BORDER); end
      end
      if (j == 407) begin
        checks++;
        if (busy_b !== 1'b1) begin errors++; $display("FAIL b_busy_last: got %b expected 1", busy_b); end
      end
      if (j == 408) begin
        checks++;
        if (busy_b !== 1'b0) begin errors++; $display("FAIL b_stop: busy=%b expected 0", busy_b); end
      end
      if (j == 411) begin
        checks++;
        if (hs_low != 51 || vs_low != 48 || de_hi != 192)
          begin errors++; $display("FAIL b_frame_counts: hs_low=%0d vs_low=%0d de=%0d expected 51 48 192",
            hs_low, vs_low, de_hi); end
      end
      if (j == 420) begin
        checks++;
        if ({hsync_out_b, vsync_out_b, de_out_b, rend_req_b, frame_start_b, busy_b} !== 6'b110000)
          begin errors++; $display("FAIL b_idle_after_stop: got %b expected 110000",
            {hsync_out_b, vsync_out_b, de_out_b, rend_req_b, frame_start_b, busy_b}); end
      end
      if (j == 101) en_b = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    en_b = 1'b1;
    @(negedge clk);              // dut_b count (0,0)
    for (int j = 0; j <= 412; j++) begin
      if (j == 3) begin
        checks++;
        if (frame_start_b !== 1'b1) begin errors++; $display("FAIL b2b_fs_first: got %b expected 1", frame_start_b); end
      end
      if (j == 408) begin
        checks++;
        if (busy_b !== 1'b1) begin errors++; $display("FAIL b2b_no_idle: busy=%b expected 1", busy_b); end
      end
      if (j == 410) begin
        checks++;
        if (frame_start_b !== 1'b0) begin errors++; $display("FAIL b2b_fs_early: got %b expected 0", frame_start_b); end
      end
      if (j == 411) begin
        checks++;
        if (frame_start_b !== 1'b1 || de_out_b !== 1'b1)
          begin errors++; $display("FAIL b2b_next_frame: fs=%b de=%b expected 1 1", frame_start_b, de_out_b); end
      end
      if (j == 101) en_b = 1'b0;
      if (j == 407) en_b = 1'b1;
      @(negedge clk);
    end
    en_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_window_and_stop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Raster scan controller for the VGA output path. Generates 640x480@60 timing counters and active-low syncs, issues render-coordinate fetch requests for a 256x180 image scaled 2x and centered on screen, and realigns syncs with returned framebuffer pixels so the colour-format stage sees matched video. Sits between the framebuffer read port and the colour-depth conversion stage.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48 (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33 (V_TOTAL = 525)
- RCoorBits, 8, width of render coordinates
- REND_W, 256 / REND_H, 180, render image size
- SCALE_LOG2, 1, log2 of pixel replication factor
- X_OFF, 64 / Y_OFF, 60, window origin in screen pixels
- FETCH_LAT, 1, framebuffer read latency in cycles (>= 1)
- bpc, 4, bits per colour; BORDER_RGB, 12'h000, border colour ({b,g,r})

- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  scan enable
- rend_req  out  1  fetch request; rendx/rendy valid
- rendx  out  RCoorBits  render x
- rendy  out  RCoorBits  render y
- rgb_in  in  bpc*3  framebuffer pixel, FETCH_LAT cycles after rend_req
- rgb_out  out  bpc*3  aligned pixel
- hsync_out  out  1  active-low horizontal sync
- vsync_out  out  1  active-low vertical sync
- de_out  out  1  active-area flag
- frame_start  out  1  one-cycle pulse with first pixel of frame
- busy  out  1  state == RUN

## Operation
- States: IDLE, RUN. IDLE: hcount = vcount = 0, pipeline fed blank (syncs 1, de 0, req 0). IDLE -> RUN when en = 1; first counted pixel (0,0) on the next cycle.
- RUN: hcount increments every cycle; at H_TOTAL-1 wraps to 0 and vcount increments; vcount wraps at V_TOTAL-1.
- en = 0 in RUN: finish current frame; at (799,524) go IDLE instead of wrapping. en = 1 again before that cycle cancels the stop.
- Stage-0 decodes: hs = !(656 <= hcount <= 751); vs = !(490 <= vcount <= 491); de = hcount < 640 && vcount < 480; win = X_OFF <= hcount < X_OFF + (REND_W << SCALE_LOG2) && same on y (64..575, 60..419).
- rendx = (hcount - X_OFF) >> SCALE_LOG2, rendy = (vcount - Y_OFF) >> SCALE_LOG2, truncated to RCoorBits; both 0 and rend_req 0 when !win.
- rgb_out: rgb_in if delayed win; else border (see Configuration); 0 if !de.
- Reset mid-operation: everything returns to reset values immediately; no frame completion.

## Timing
- Counter cycle t: rend_req/rendx/rendy registered at t+1; rgb_in valid at t+1+FETCH_LAT; rgb_out, hsync_out, vsync_out, de_out, frame_start registered at t+2+FETCH_LAT. Total latency L = FETCH_LAT+2 (3 at default).
- Sync/de delay line is L stages, all reset-cleared.
- Reset values: hsync_out 1, vsync_out 1, de_out 0, rgb_out 0, rend_req 0, rendx 0, rendy 0, frame_start 0, busy 0, state IDLE.
- busy drops the cycle after the (799,524) count; pipeline still drains L cycles of blank-correct output afterwards.

## Configuration
- VGA_SCAN_BORDER_EN defined: active pixels outside the render window output BORDER_RGB.
- Undefined: those pixels output 0; BORDER_RGB unused.

## Test plan
- Reset asserted mid-line at hcount 300 -> all outputs at reset values same cycle; after release with en = 1, scan restarts at (0,0).
- en raised from IDLE -> first rend_req 48065 cycles after first counted pixel, rendx = 0, rendy = 0; rendx = 1 at hcount 66.
- Free run -> hsync_out low exactly 96 of every 800 cycles; vsync_out low 1600 of every 420000 cycles; de_out high 640 per line, 480 lines.
- Window edge -> at (575,419) rendx = 255, rendy = 179, rend_req 1; at (576,419) rend_req 0, rendx = 0.
- en dropped at (100,200) -> frame completes, busy 0 after (799,524); en reasserted at (799,524) -> no IDLE, next frame starts.
- rgb_in = 12'hFFF constant, BORDER_RGB = 12'h00F -> at screen (10,10) rgb_out = 12'h00F with macro, 12'h000 without; at (64,60) rgb_out = 12'hFFF three cycles after count.
